fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 pipeline.
- Owns the program counter and drives the combinational instruction ROM address. Captures the returned 32-bit word into the IF/ID pipeline register.
- Handles branch redirects, decode-requested stalls, and halting at the end of instruction memory.
- Exposes fetch and stall performance counters for the benches.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
IMEM_SIZE, 1024, instruction memory size in bytes; power of two, >4
NOP_INSTR, 32'hD503201F, word placed in ifid_instr for bubbles

Ports:
clk  input  1  clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
imem_addr  output  64  byte address to instruction ROM; equals pc
imem_instr  input  32  combinational instruction word for imem_addr
stall  input  1  hold PC and IF/ID contents (load-use hazard)
br_taken  input  1  redirect request from EX/ID
br_target  input  64  redirect byte address
ifid_pc  output  64  PC of the instruction held in IF/ID
ifid_instr  output  32  instruction held in IF/ID
ifid_valid  output  1  IF/ID holds a real instruction
halted  output  1  state is HALT
err_misalign  output  1  sticky: a redirect target had bits [1:0] != 0
fetch_count  output  32  instructions captured into IF/ID
stall_count  output  32  cycles with stall=1 in RUN

Behaviour:
- Reset (reset_n=0, async, any time):
  - pc=RESET_PC; state=RUN.
  - ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0.
  - err_misalign=0; both counters=0.
- imem_addr = pc, combinationally, at all times.
- Signal oob = (pc + 3 >= IMEM_SIZE), computed in 64-bit unsigned arithmetic.
- State RUN, per cycle, priority highest first:
  1. br_taken=1: pc <= {br_target[63:2],2'b00}; IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc=0). If br_target[1:0]!=0, set err_misalign. Redirect overrides stall.
  2. stall=1: pc and IF/ID hold; stall_count increments.
  3. oob=1: state <= HALT; IF/ID <= bubble; pc holds.
  4. Otherwise: ifid_instr <= imem_instr; ifid_pc <= pc; ifid_valid <= 1; pc <= pc + 4 (wraps mod 2^64); fetch_count increments.
- State HALT:
  - halted=1; pc holds; IF/ID holds bubble; stall is ignored and not counted.
  - br_taken=1 loads the target exactly as in RUN and returns state to RUN, so an older in-flight branch can still redirect.
- Latency: instruction at address A appears on ifid_instr one cycle after pc==A with stall=0. A redirect takes effect on the next edge; first target instruction is valid in IF/ID two edges after br_taken.
- Counters saturate at 32'hFFFFFFFF; they do not wrap.
- halted is a decode of state, with no extra cycle of delay.
- Misaligned pc is impossible: the low bits of pc are forced to 0 on every load.

Test Plan:
- Reset release, ROM words W0..W3 at 0x0..0xC, stall=0 → ifid_valid low for the first edge. ifid_pc/instr then step 0/W0, 4/W1, 8/W2, 0xC/W3 on successive edges; fetch_count=4.
- Stall=1 for 3 cycles while pc=0x8 → pc stays 0x8, ifid_pc stays 0x4, stall_count=3. After release, ifid_pc=0x8 next edge.
- br_taken=1 with br_target=0x40 and stall=1 in the same cycle → next edge pc=0x40, ifid_valid=0, ifid_instr=NOP_INSTR. The edge after: ifid_pc=0x40, valid=1.
- Run to pc=0x3FC (IMEM_SIZE=1024) → 0x3FC is fetched. The next cycle pc=0x400 is oob: halted=1, ifid_valid=0, pc stays 0x400. A subsequent br_taken to 0x10 → halted=0, then ifid_pc=0x10 valid.
- br_target=0x22 → pc=0x20, err_misalign=1. It stays 1 through later normal redirects until reset.
- Assert reset_n=0 mid-run, asynchronously between edges → outputs go immediately to reset values (pc=RESET_PC, ifid_valid=0, counters=0) without waiting for clk.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction-fetch stage: PC, IF/ID register, redirect/stall/halt, perf counters
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned IMEM_SIZE = 1024,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted,
  output logic        err_misalign,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  localparam logic [63:0] IMEM_LIMIT  = 64'(IMEM_SIZE);
  localparam logic [63:0] RESET_PC_AL = {RESET_PC[63:2], 2'b00};

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic        r_err_misalign;
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  logic [63:0] w_pc_last_byte;
  logic        w_oob;

  // Last byte of the word at pc must lie inside the ROM; 64-bit wrap is intentional.
  assign w_pc_last_byte = r_pc + 64'd3;
  assign w_oob          = (w_pc_last_byte >= IMEM_LIMIT);

  assign imem_addr    = r_pc;
  assign ifid_pc      = r_ifid_pc;
  assign ifid_instr   = r_ifid_instr;
  assign ifid_valid   = r_ifid_valid;
  assign halted       = (r_state == ST_HALT);
  assign err_misalign = r_err_misalign;
  assign fetch_count  = r_fetch_count;
  assign stall_count  = r_stall_count;

  // Fetch FSM: redirect beats everything (also wakes HALT), then stall, then end-of-ROM, then fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC_AL;
      r_ifid_pc      <= 64'd0;
      r_ifid_instr   <= NOP_INSTR;
      r_ifid_valid   <= 1'b0;
      r_err_misalign <= 1'b0;
      r_fetch_count  <= 32'd0;
      r_stall_count  <= 32'd0;
    end else if (br_taken) begin
      r_state      <= ST_RUN;
      r_pc         <= {br_target[63:2], 2'b00};
      r_ifid_pc    <= 64'd0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      if (br_target[1:0] != 2'b00) begin
        r_err_misalign <= 1'b1;
      end
    end else if (r_state == ST_RUN) begin
      if (stall) begin
        if (r_stall_count != 32'hFFFF_FFFF) begin
          r_stall_count <= r_stall_count + 32'd1;
        end
      end else if (w_oob) begin
        r_state      <= ST_HALT;
        r_ifid_pc    <= 64'd0;
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end else begin
        r_ifid_pc    <= r_pc;
        r_ifid_instr <= imem_instr;
        r_ifid_valid <= 1'b1;
        r_pc         <= r_pc + 64'd4;
        if (r_fetch_count != 32'hFFFF_FFFF) begin
          r_fetch_count <= r_fetch_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;
  logic        err_misalign;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'd0, a[15:0]};
  endfunction

  assign imem_instr = rom_word(imem_addr);

  fetch_stage #(
    .RESET_PC (64'd0),
    .IMEM_SIZE(1024),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .err_misalign(err_misalign),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected IF/ID entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ifid_valid", 64'(ifid_valid), 64'(mon_e.v));
      chk("ifid_pc",    ifid_pc,         mon_e.pc);
      chk("ifid_instr", 64'(ifid_instr), 64'(mon_e.ins));
    end
  end

  task automatic cyc(input logic s, input logic b, input logic [63:0] t,
                     input logic ev, input logic [63:0] epc, input logic [31:0] eins);
    exp_t e;
    stall     = s;
    br_taken  = b;
    br_target = t;
    @(posedge clk);
    e.v = ev; e.pc = epc; e.ins = eins;
    exp_q.push_back(e);
    #1;
    stall    = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] pc);
    cyc(1'b0, 1'b0, 64'd0, 1'b1, pc, rom_word(pc));
  endtask

  task automatic bubble(input logic s, input logic b, input logic [63:0] t);
    cyc(s, b, t, 1'b0, 64'd0, NOP);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 64'd0;
    #12;
    chk("rst imem_addr",   imem_addr,           64'd0);
    chk("rst ifid_valid",  64'(ifid_valid),     64'd0);
    chk("rst ifid_instr",  64'(ifid_instr),     64'(NOP));
    chk("rst ifid_pc",     ifid_pc,             64'd0);
    chk("rst halted",      64'(halted),         64'd0);
    chk("rst err",         64'(err_misalign),   64'd0);
    chk("rst fetch_count", 64'(fetch_count),    64'd0);
    chk("rst stall_count", 64'(stall_count),    64'd0);
    reset_n = 1'b1;

    fetch(64'h0);
    fetch(64'h4);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 64'd0, 1'b1, 64'h4, rom_word(64'h4));
    chk("stall pc held",   imem_addr,        64'h8);
    chk("stall_count 3",   64'(stall_count), 64'd3);
    fetch(64'h8);
    fetch(64'hC);
    chk("fetch_count 4",   64'(fetch_count), 64'd4);

    bubble(1'b1, 1'b1, 64'h40);
    chk("redir pc",        imem_addr,        64'h40);
    chk("redir no stallcnt", 64'(stall_count), 64'd3);
    fetch(64'h40);
    chk("fetch_count 5",   64'(fetch_count), 64'd5);

    bubble(1'b0, 1'b1, 64'h22);
    chk("misalign pc",     imem_addr,          64'h20);
    chk("misalign err",    64'(err_misalign),  64'd1);
    fetch(64'h20);
    bubble(1'b0, 1'b1, 64'h3F0);
    chk("err sticky",      64'(err_misalign),  64'd1);
    for (int i = 0; i < 4; i++) fetch(64'h3F0 + 64'(4 * i));
    chk("fetch_count 10",  64'(fetch_count), 64'd10);
    chk("pc at end",       imem_addr,        64'h400);
    chk("not yet halted",  64'(halted),      64'd0);
    bubble(1'b0, 1'b0, 64'd0);
    chk("halted",          64'(halted),      64'd1);
    chk("halt pc held",    imem_addr,        64'h400);
    bubble(1'b1, 1'b0, 64'd0);
    chk("halt stall ignored", 64'(stall_count), 64'd3);
    chk("still halted",    64'(halted),      64'd1);
    bubble(1'b0, 1'b1, 64'h10);
    chk("unhalt",          64'(halted),      64'd0);
    chk("unhalt pc",       imem_addr,        64'h10);
    fetch(64'h10);
    chk("fetch_count 11",  64'(fetch_count), 64'd11);

    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async imem_addr",   imem_addr,         64'd0);
    chk("async ifid_valid",  64'(ifid_valid),   64'd0);
    chk("async ifid_instr",  64'(ifid_instr),   64'(NOP));
    chk("async fetch_count", 64'(fetch_count),  64'd0);
    chk("async stall_count", 64'(stall_count),  64'd0);
    chk("async err",         64'(err_misalign), 64'd0);
    #4;
    reset_n = 1'b1;
    fetch(64'h0);
    chk("post-reset fetch_count", 64'(fetch_count), 64'd1);

    @(negedge clk);
    #1;
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
